csm_sim_s00_axi_regfile: RTL and testbench
==========================================

// Module: csm_sim_s00_axi_regfile
// PURPOSE
//  AXI4-Lite slave register file for the CSM simulator IP (S00_AXI port).
//  Terminates the processor/VIP master, holds NUM_REGS 32-bit control words,
//  drives them to the simulator core, and pulses a per-register write strobe
//  on every committed write. All registers are read-write with full readback.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 is supported.
//  C_S_AXI_ADDR_WIDTH  4   byte address width; decode uses bits [ADDR_W-1:2].
//  NUM_REGS            4   number of registers; must equal 2**(ADDR_W-2).
// PORTS
//  ACLK           in   1       single clock, all logic on rising edge
//  ARESET         in   1       async, active-high reset
//  S_AXI_AWADDR   in   ADDR_W  write address
//  S_AXI_AWPROT   in   3       ignored
//  S_AXI_AWVALID  in   1       write address valid
//  S_AXI_AWREADY  out  1       write address ready
//  S_AXI_WDATA    in   32      write data
//  S_AXI_WSTRB    in   4       byte enables
//  S_AXI_WVALID   in   1       write data valid
//  S_AXI_WREADY   out  1       write data ready
//  S_AXI_BRESP    out  2       always 2'b00 (OKAY)
//  S_AXI_BVALID   out  1       write response valid
//  S_AXI_BREADY   in   1       write response ready
//  S_AXI_ARADDR   in   ADDR_W  read address
//  S_AXI_ARPROT   in   3       ignored
//  S_AXI_ARVALID  in   1       read address valid
//  S_AXI_ARREADY  out  1       read address ready
//  S_AXI_RDATA    out  32      read data
//  S_AXI_RRESP    out  2       always 2'b00 (OKAY)
//  S_AXI_RVALID   out  1       read data valid
//  S_AXI_RREADY   in   1       read data ready
//  regs_o         out  32*NUM_REGS  register contents, reg k at [32k+31:32k]
//  reg_wr_o       out  NUM_REGS one-cycle pulse when reg k is written
// BEHAVIOUR
//  Reset (async): all regs 0, regs_o 0, reg_wr_o 0, all VALID/READY 0,
//   RDATA 0, holding slots empty. Readies assert on first edge after release.
//  Write path: AW and W are independent one-entry slots (aw_full, w_full).
//   AWREADY = registered !aw_full; WREADY = registered !w_full.
//   Handshake on edge N fills slot; either order and any skew allowed.
//   Commit edge: aw_full & w_full & (!BVALID | BREADY). On commit: bytes of
//   reg[AWADDR[ADDR_W-1:2]] with WSTRB=1 updated, others kept; BVALID<=1;
//   reg_wr_o[k] high for the cycle after commit; both slots cleared.
//   AW+W accepted same edge N -> commit N+1 -> BVALID and new regs_o after N+1.
//   BVALID held until BREADY; while held, next AW/W may be accepted into
//   slots but no commit occurs (backpressure, max one write buffered).
//   AWADDR[1:0] ignored; no SLVERR generated.
//  Read path: ARREADY = registered !RVALID & !ar_pending. AR handshake on
//   edge N -> RDATA = reg[ARADDR[ADDR_W-1:2]] sampled at N+1, RVALID=1.
//   RDATA/RVALID held stable until RREADY; then RVALID drops next edge.
//  Simultaneous: a read captured on the same edge as a write commit to the
//   same register returns the OLD value. Read and write channels fully
//   independent; no ordering between them.
//  Reset mid-transaction: in-flight AW/W/AR discarded, B/R VALID drop
//   immediately, register contents return to 0.
// TESTING
//  1 Write 1,2,3,4 to 0x0,0x4,0x8,0xC, read back -> RDATA 1,2,3,4, RRESP OKAY,
//    BRESP OKAY, reg_wr_o pulses 0001,0010,0100,1000 one cycle each.
//  2 Reg1=0xFFFFFFFF, write 0x12345678 WSTRB=4'b0101 to 0x4 -> read 0xFF34FF78.
//  3 WVALID 3 cycles before AWVALID, data 0xA5A5A5A5 @0x8 -> single commit
//    after AW handshake, regs_o[95:64]=0xA5A5A5A5, exactly one BVALID.
//  4 BREADY held low 10 cycles, second write issued -> second AW/W accepted,
//    AWREADY/WREADY then low, reg unchanged until first B taken; 2 B total.
//  5 AR @0xC with RREADY low 5 cycles -> RDATA stable, ARREADY low throughout;
//    AR @0x0 same edge as write commit to 0x0 -> old value returned.
//  6 Assert ARESET between AW and W handshakes -> BVALID never rises,
//    regs_o all 0, readies 0 then 1 on first edge after release.

Source files
------------

// File: rtl/csm_sim_s00_axi_regfile.sv
// rtl/csm_sim_s00_axi_regfile.sv - AXI4-Lite register file for the CSM simulator S00_AXI port
module csm_sim_s00_axi_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_o,
    output logic [NUM_REGS-1:0]               reg_wr_o
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = AW - 2;

    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]         reg_wr_q, reg_wr_d;
    logic                        aw_full_q, aw_full_d;
    logic [IDX_W-1:0]            aw_idx_q, aw_idx_d;
    logic                        w_full_q, w_full_d;
    logic [DW-1:0]               w_data_q, w_data_d;
    logic [DW/8-1:0]             w_strb_q, w_strb_d;
    logic                        awready_q, awready_d;
    logic                        wready_q, wready_d;
    logic                        bvalid_q, bvalid_d;
    logic                        ar_pending_q, ar_pending_d;
    logic [IDX_W-1:0]            ar_idx_q, ar_idx_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q, rvalid_d;
    logic [DW-1:0]               rdata_q, rdata_d;
    logic                        commit;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // A buffered write may only retire once the previous response is free or leaving.
    assign commit = aw_full_q & w_full_q & (~bvalid_q | S_AXI_BREADY);

    always_comb begin
        regs_d   = regs_q;
        reg_wr_d = '0;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;

        if (commit) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (w_strb_q[b]) begin
                    regs_d[aw_idx_q][8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
            reg_wr_d[aw_idx_q] = 1'b1;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (S_AXI_AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[AW-1:2];
        end
        if (S_AXI_WVALID && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
    end

    // Read data is sampled from regs_q, so a same-edge commit yields the old value.
    always_comb begin
        ar_pending_d = ar_pending_q;
        ar_idx_d     = ar_idx_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;

        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_pending_q) begin
            rvalid_d     = 1'b1;
            rdata_d      = regs_q[ar_idx_q];
            ar_pending_d = 1'b0;
        end
        if (S_AXI_ARVALID && arready_q) begin
            ar_pending_d = 1'b1;
            ar_idx_d     = S_AXI_ARADDR[AW-1:2];
        end
        arready_d = ~rvalid_d & ~ar_pending_d;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q       <= '0;
            reg_wr_q     <= '0;
            aw_full_q    <= 1'b0;
            aw_idx_q     <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            ar_pending_q <= 1'b0;
            ar_idx_q     <= '0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            regs_q       <= regs_d;
            reg_wr_q     <= reg_wr_d;
            aw_full_q    <= aw_full_d;
            aw_idx_q     <= aw_idx_d;
            w_full_q     <= w_full_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            ar_pending_q <= ar_pending_d;
            ar_idx_q     <= ar_idx_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign regs_o        = regs_q;
    assign reg_wr_o      = reg_wr_q;
endmodule

// File: tb/tb_csm_sim_s00_axi_regfile.sv
// tb/tb_csm_sim_s00_axi_regfile.sv - scoreboard bench for csm_sim_s00_axi_regfile
module tb_csm_sim_s00_axi_regfile;
    logic         clk = 1'b0;
    logic         ARESET;
    logic [3:0]   AWADDR, ARADDR;
    logic [2:0]   AWPROT, ARPROT;
    logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic         ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]  WDATA, RDATA;
    logic [3:0]   WSTRB;
    logic [1:0]   BRESP, RRESP;
    logic [127:0] regs_o;
    logic [3:0]   reg_wr_o;

    int total = 0;
    int bad = 0;
    int bcount = 0;
    int rcount = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  wr_log[$];
    logic [31:0] m [4];

    always #5 clk = ~clk;

    csm_sim_s00_axi_regfile dut (
        .ACLK(clk), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .regs_o(regs_o), .reg_wr_o(reg_wr_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitors observe handshakes at the negedge preceding the completing posedge.
    always @(negedge clk) begin
        if (!ARESET && RVALID && RREADY) begin
            if (exp_q.size() == 0) chk("r_unexpected", 1, 0);
            else chk("rdata", RDATA, exp_q.pop_front());
            chk("rresp", RRESP, 0);
            rcount++;
        end
        if (!ARESET && BVALID && BREADY) begin
            chk("bresp", BRESP, 0);
            bcount++;
        end
        if (reg_wr_o != 0) wr_log.push_back(reg_wr_o);
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic aw_send(input logic [3:0] a);
        bit ok;
        ok = 0;
        AWADDR = a; AWVALID = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (AWREADY) begin @(posedge clk); #1; ok = 1; end
        end
        AWVALID = 0;
        if (!ok) chk("aw_timeout", 0, 1);
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 0;
        WDATA = d; WSTRB = s; WVALID = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (WREADY) begin @(posedge clk); #1; ok = 1; end
        end
        WVALID = 0;
        if (!ok) chk("w_timeout", 0, 1);
    endtask

    task automatic ar_send(input logic [3:0] a);
        bit ok;
        ok = 0;
        ARADDR = a; ARVALID = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ARREADY) begin @(posedge clk); #1; ok = 1; end
        end
        ARVALID = 0;
        if (!ok) chk("ar_timeout", 0, 1);
    endtask

    task automatic wait_b(input int target);
        for (int i = 0; i < 60 && bcount < target; i++) begin @(posedge clk); #1; end
        if (bcount < target) chk("b_timeout", bcount, target);
    endtask

    task automatic wait_r(input int target);
        for (int i = 0; i < 60 && rcount < target; i++) begin @(posedge clk); #1; end
        if (rcount < target) chk("r_timeout", rcount, target);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        t = bcount + 1;
        fork
            aw_send(a);
            w_send(d, s);
        join
        m[a[3:2]] = merge(m[a[3:2]], d, s);
        wait_b(t);
    endtask

    task automatic rd(input logic [3:0] a);
        int t;
        t = rcount + 1;
        exp_q.push_back(m[a[3:2]]);
        ar_send(a);
        wait_r(t);
    endtask

    initial begin
        int b0;
        int r0;
        ARESET = 1; AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0;
        AWVALID = 0; WVALID = 0; ARVALID = 0; WDATA = 0; WSTRB = 0;
        BREADY = 1; RREADY = 1;
        for (int i = 0; i < 4; i++) m[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_regs", regs_o, 0);
        chk("rst_rdata", RDATA, 0);
        ARESET = 0;
        @(posedge clk); #1;
        chk("rel_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Basic writes and readback with one-hot write strobes.
        wr_log.delete();
        for (int k = 0; k < 4; k++) wr(4'(4 * k), 32'(k + 1), 4'hF);
        chk("t1_nwr", wr_log.size(), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++) chk("t1_wrpulse", wr_log[k], 4'b0001 << k);
        for (int k = 0; k < 4; k++) rd(4'(4 * k));

        // Partial byte strobes.
        wr(4'h4, 32'hFFFF_FFFF, 4'hF);
        wr(4'h4, 32'h1234_5678, 4'b0101);
        chk("t2_model", m[1], 32'hFF34_FF78);
        rd(4'h4);

        // W leads AW by three cycles.
        b0 = bcount;
        fork
            w_send(32'hA5A5_A5A5, 4'hF);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("t3_noB", BVALID, 0);
                chk("t3_old", regs_o[95:64], m[2]);
                aw_send(4'h8);
            end
        join
        m[2] = 32'hA5A5_A5A5;
        wait_b(b0 + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_oneB", bcount, b0 + 1);
        chk("t3_reg", regs_o[95:64], 32'hA5A5_A5A5);

        // Backpressure on B: second write buffered, not committed.
        b0 = bcount;
        BREADY = 0;
        fork aw_send(4'hC); w_send(32'h1111_1111, 4'hF); join
        fork aw_send(4'hC); w_send(32'h2222_2222, 4'hF); join
        repeat (2) @(posedge clk);
        #1;
        chk("t4_awready", AWREADY, 0);
        chk("t4_wready", WREADY, 0);
        chk("t4_bvalid", BVALID, 1);
        chk("t4_reg_first", regs_o[127:96], 32'h1111_1111);
        chk("t4_nob", bcount, b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t4_reg_held", regs_o[127:96], 32'h1111_1111);
        BREADY = 1;
        wait_b(b0 + 2);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_twoB", bcount, b0 + 2);
        chk("t4_reg_second", regs_o[127:96], 32'h2222_2222);
        m[3] = 32'h2222_2222;

        // R held under backpressure.
        r0 = rcount;
        RREADY = 0;
        exp_q.push_back(m[3]);
        ar_send(4'hC);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_rvalid", RVALID, 1);
            chk("t5_rdata", RDATA, m[3]);
            chk("t5_arready", ARREADY, 0);
        end
        @(posedge clk); #1;
        RREADY = 1;
        wait_r(r0 + 1);

        // Read captured on the same edge as a commit to the same register.
        r0 = rcount;
        b0 = bcount;
        exp_q.push_back(m[0]);
        fork
            aw_send(4'h0);
            w_send(32'hDEAD_BEEF, 4'hF);
            ar_send(4'h0);
        join
        wait_b(b0 + 1);
        wait_r(r0 + 1);
        m[0] = 32'hDEAD_BEEF;
        rd(4'h0);

        // Reset between AW and W handshakes.
        b0 = bcount;
        aw_send(4'h8);
        #2;
        ARESET = 1;
        #1;
        chk("t6_regs", regs_o, 0);
        chk("t6_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        chk("t6_bvalid", BVALID, 0);
        repeat (2) @(posedge clk);
        #2;
        ARESET = 0;
        #1;
        chk("t6_readies_lo", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge clk); #1;
        chk("t6_readies_hi", {AWREADY, WREADY, ARREADY}, 3'b111);
        for (int i = 0; i < 4; i++) m[i] = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_noB", bcount, b0);
        chk("t6_regs_after", regs_o, 0);
        wr(4'h8, 32'hCAFE_0001, 4'hF);
        rd(4'h8);
        rd(4'h4);

        repeat (3) @(posedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
